// File: rtl/alu_seq_nbit_pkg.sv
// Shared opcodes, FSM states and helpers for the sequential EX-stage ALU.
package alu_seq_nbit_pkg;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_PASS   = 5'd10;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // M-ops occupy 16..23; low three bits select the engine function
    function automatic logic is_mop(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_iter_nbit.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes.
module muldiv_iter_nbit
    import alu_seq_nbit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         kill,
    input  logic [2:0]   fn,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         last,
    output logic [N-1:0] result
);

    localparam int CW = $clog2(N);

    logic           run;
    logic [CW-1:0]  cnt;
    logic [2:0]     fn_q;
    logic           sa;
    logic           sb;
    logic           div0;
    logic           ovf;
    logic [N-1:0]   a_q;
    logic [N-1:0]   opnd;
    logic [N-1:0]   hi;
    logic [N-1:0]   lo;

    logic           sgn_a;
    logic           sgn_b;
    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N:0]     mul_sum;
    logic [N+1:0]   trial;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo;
    logic [N-1:0]   rem;

    // fn: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
    always_comb begin
        sgn_a   = a[N-1] & (fn == 3'd1 || fn == 3'd2 || fn == 3'd4 || fn == 3'd6);
        sgn_b   = b[N-1] & (fn == 3'd1 || fn == 3'd4 || fn == 3'd6);
        mag_a   = sgn_a ? -a : a;
        mag_b   = sgn_b ? -b : b;
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        trial   = {1'b0, hi, lo[N-1]} - {2'b00, opnd};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run  <= 1'b0;
            cnt  <= '0;
            fn_q <= '0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            div0 <= 1'b0;
            ovf  <= 1'b0;
            a_q  <= '0;
            opnd <= '0;
            hi   <= '0;
            lo   <= '0;
        end else if (kill) begin
            run <= 1'b0;
        end else if (load) begin
            run  <= 1'b1;
            cnt  <= '0;
            fn_q <= fn;
            sa   <= sgn_a;
            sb   <= sgn_b;
            a_q  <= a;
            div0 <= (b == '0);
            ovf  <= (fn == 3'd4 || fn == 3'd6)
                    && a == {1'b1, {(N-1){1'b0}}} && b == '1;
            hi   <= '0;
            opnd <= fn[2] ? mag_b : mag_a;
            lo   <= fn[2] ? mag_a : mag_b;
        end else if (run) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N-1))
                run <= 1'b0;
            if (fn_q[2]) begin
                if (!trial[N+1]) begin
                    hi <= trial[N-1:0];
                    lo <= {lo[N-2:0], 1'b1};
                end else begin
                    hi <= {hi[N-2:0], lo[N-1]};
                    lo <= {lo[N-2:0], 1'b0};
                end
            end else begin
                {hi, lo} <= {mul_sum, lo[N-1:1]};
            end
        end
    end

    assign last = run && (cnt == CW'(N-1));

    always_comb begin
        prod = {hi, lo};
        if (sa ^ sb)
            prod = -prod;
        quo = (sa ^ sb) ? -lo : lo;
        rem = sa ? -hi : hi;
        if (!fn_q[2])
            result = (fn_q[1:0] == 2'd0) ? prod[N-1:0] : prod[2*N-1:N];
        else if (div0)
            result = fn_q[1] ? a_q : '1;
        else if (ovf)
            result = fn_q[1] ? '0 : {1'b1, {(N-1){1'b0}}};
        else
            result = fn_q[1] ? rem : quo;
    end

endmodule

// File: rtl/alu_seq_nbit.sv
// Multi-cycle EX-stage ALU: single-cycle basic ops plus iterative RV32M.
module alu_seq_nbit
    import alu_seq_nbit_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         kill,
    input  logic [4:0]   alu_control,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] ALUout,
    output logic         Z,
    output logic         C,
    output logic         V,
    output logic         S
);

    state_t         state;
    logic           accept;
    logic           mop;
    logic [SHW-1:0] sh;
    logic [N:0]     add_w;
    logic [N:0]     sub_w;
    logic [N-1:0]   basic;
    logic           basic_c;
    logic           basic_v;
    logic           md_last;
    logic [N-1:0]   md_res;

    assign mop    = is_mop(alu_control);
    assign accept = start && !busy && !kill;
    assign sh     = B[SHW-1:0];

    muldiv_iter_nbit #(.N(N)) u_md (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && mop),
        .kill   (kill),
        .fn     (alu_control[2:0]),
        .a      (A),
        .b      (B),
        .last   (md_last),
        .result (md_res)
    );

    always_comb begin
        add_w   = {1'b0, A} + {1'b0, B};
        sub_w   = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
        basic   = '0;
        basic_c = 1'b0;
        basic_v = 1'b0;
        case (alu_control)
            ALU_ADD: begin
                basic   = add_w[N-1:0];
                basic_c = add_w[N];
                basic_v = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
            end
            ALU_SUB: begin
                basic   = sub_w[N-1:0];
                basic_c = sub_w[N];
                basic_v = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
            end
            ALU_AND:  basic = A & B;
            ALU_OR:   basic = A | B;
            ALU_XOR:  basic = A ^ B;
            ALU_SLL:  basic = A << sh;
            ALU_SRL:  basic = A >> sh;
            ALU_SRA:  basic = N'($signed(A) >>> sh);
            ALU_SLT:  basic = {{(N-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU: basic = {{(N-1){1'b0}}, A < B};
            ALU_PASS: basic = A;
            default:  basic = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            ALUout <= '0;
            C      <= 1'b0;
            V      <= 1'b0;
        end else if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                    if (start && mop) begin
                        state <= S_ITER;
                        busy  <= 1'b1;
                    end else if (start) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        ALUout <= basic;
                        C      <= basic_c;
                        V      <= basic_v;
                    end
                end
                S_ITER: begin
                    if (md_last)
                        state <= S_FIX;
                end
                S_FIX: begin
                    ALUout <= md_res;
                    C      <= 1'b0;
                    V      <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign Z = (ALUout == '0);
    assign S = ALUout[N-1];

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed and randomized self-checking bench for alu_seq_nbit (N=32).
module tb_alu_seq_nbit;
    import alu_seq_nbit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [4:0]  alu_control = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, Z, C, V, S;
    logic [31:0] ALUout;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_nbit #(.N(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .kill        (kill),
        .alu_control (alu_control),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .ALUout      (ALUout),
        .Z           (Z),
        .C           (C),
        .V           (V),
        .S           (S)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        logic [63:0] p;
        int sh = int'(b[4:0]);
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_ADD:    return 32'(sa + sb);
            ALU_SUB:    return 32'(sa - sb);
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLL:    return a << sh;
            ALU_SRL:    return a >> sh;
            ALU_SRA:    return 32'($signed(a) >>> sh);
            ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
            ALU_PASS:   return a;
            ALU_MUL:    begin p = 64'(ua * ub); return p[31:0]; end
            ALU_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            ALU_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            ALU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            ALU_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_cv(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint r;
        logic c, v;
        if (op == ALU_ADD) begin
            r = sa + sb;
            c = (longint'(a) + longint'(b)) > 64'sd4294967295;
        end else if (op == ALU_SUB) begin
            r = sa - sb;
            c = (a >= b);
        end else begin
            return 2'b00;
        end
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {c, v};
    endfunction

    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int lat = 1;
        int bcnt = 0;
        logic [31:0] er = model(op, a, b);
        logic [1:0] ecv = model_cv(op, a, b);
        int elat = is_mop(op) ? 34 : 1;
        @(negedge clk);
        alu_control = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".busy"}, 64'(bcnt), 64'(elat - 1));
        check({tag, ".res"}, 64'(ALUout), 64'(er));
        check({tag, ".Z"}, 64'(Z), 64'(er == 0));
        check({tag, ".S"}, 64'(S), 64'(er[31]));
        check({tag, ".C"}, 64'(C), 64'(ecv[1]));
        check({tag, ".V"}, 64'(V), 64'(ecv[0]));
        @(posedge clk); #1;
        check({tag, ".pulse"}, 64'(done), 64'(0));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0] ops [20];
        logic [31:0] prev;
        int n_done;
        int done_at;
        logic [31:0] got;
        ops = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
                ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS, ALU_MUL, ALU_MULH,
                ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, 5'd13};

        #1;
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.done", 64'(done), 64'(0));
        check("rst.out", 64'(ALUout), 64'(0));
        check("rst.flags", 64'({Z, C, V, S}), 64'(4'b1000));
        #20 rst = 1'b0;

        run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        run_op("sub_eq", ALU_SUB, 32'd5, 32'd5);
        run_op("sra", ALU_SRA, 32'h8000_0000, 32'd31);
        run_op("srl", ALU_SRL, 32'h8000_0000, 32'd31);
        run_op("sll0", ALU_SLL, 32'h1234_5678, 32'h20);
        run_op("undef", 5'd27, 32'hDEAD_BEEF, 32'd3);
        run_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem", ALU_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("divu0", ALU_DIVU, 32'd7, 32'd0);
        run_op("remu0", ALU_REMU, 32'd7, 32'd0);
        run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF);

        // start pulses while busy must be ignored
        @(negedge clk);
        alu_control = ALU_MULHU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; done_at = 0; got = '0;
        for (int i = 2; i <= 40; i++) begin
            if (i >= 3 && i <= 6) begin
                start = 1'b1; alu_control = ALU_ADD; A = 32'd1; B = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                n_done++; done_at = i; got = ALUout;
            end
        end
        check("ign.count", 64'(n_done), 64'(1));
        check("ign.lat", 64'(done_at), 64'(34));
        check("ign.res", 64'(got), 64'(32'hFFFF_FFFE));

        // kill at ITER cycle 10
        prev = ALUout;
        @(negedge clk);
        alu_control = ALU_DIV; A = 32'd100; B = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill.busy", 64'(busy), 64'(0));
        check("kill.done", 64'(done), 64'(0));
        check("kill.out", 64'(ALUout), 64'(prev));
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("kill.nodone", 64'(n_done), 64'(0));

        // kill and start together: kill wins
        @(negedge clk);
        alu_control = ALU_ADD; A = 32'd9; B = 32'd9; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("killst.done", 64'(done), 64'(0));
        check("killst.out", 64'(ALUout), 64'(prev));

        // asynchronous reset mid-divide
        run_op("pre_rst", ALU_ADD, 32'd40, 32'd2);
        @(negedge clk);
        alu_control = ALU_DIV; A = 32'd1000; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.busy", 64'(busy), 64'(0));
        check("arst.out", 64'(ALUout), 64'(0));
        check("arst.flags", 64'({Z, C, V, S}), 64'(4'b1000));
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst", ALU_DIV, 32'd1000, 32'd7);

        for (int k = 0; k < 40; k++)
            run_op($sformatf("rnd%0d", k), ops[$urandom_range(0, 19)], pick(), pick());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
